reg_file: RTL and testbench

Architectural integer register file for the 5-stage RV32 pipeline: the consumer end of the writeback path. It accepts the write-back triple (data, destination, write-enable) from the WB stage and serves two combinational read ports to the ID stage. It forwards same-cycle writes to the read ports so the WB→ID hazard needs no separate bypass. It also emits a registered commit trace and a count of retired register writes for the verification bench and debug.

---
 rtl/reg_file.sv | 125 ++++++++++++
 tb/tb_reg_file.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file
//
// Architectural integer register file for the 5-stage RV32 pipeline. This is
// the consumer end of the writeback path. It holds x1..x(REG_COUNT-1); x0 has
// no storage and always reads zero. Two combinational read ports serve the ID
// stage. A same-cycle write is forwarded to a matching read port, so the
// WB->ID hazard needs no separate bypass network. A registered commit trace and
// a wrapping count of retired writes are provided for the bench and for debug.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset
//   i_WriteData     write-back data from WB
//   i_ctrl_RegWrite write enable from WB
//   i_Rd            destination register index from WB
//   i_Rs1, i_Rs2    read port indices from ID
//   o_Rs1_Data      read port 1 data (combinational)
//   o_Rs2_Data      read port 2 data (combinational)
//   o_Commit_Valid  a register write committed at the last edge
//   o_Commit_Rd     destination of the most recent commit
//   o_Commit_Data   data of the most recent commit
//   o_Write_Count   committed writes since reset, wraps silently
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_WriteData,
  input  logic                  i_ctrl_RegWrite,
  input  logic [4:0]            i_Rd,
  input  logic [4:0]            i_Rs1,
  input  logic [4:0]            i_Rs2,
  output logic [DATA_WIDTH-1:0] o_Rs1_Data,
  output logic [DATA_WIDTH-1:0] o_Rs2_Data,
  output logic                  o_Commit_Valid,
  output logic [4:0]            o_Commit_Rd,
  output logic [DATA_WIDTH-1:0] o_Commit_Data,
  output logic [31:0]           o_Write_Count
);

  logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];
  logic [DATA_WIDTH-1:0] regs_d [1:REG_COUNT-1];

  logic                  commitValid_q, commitValid_d;
  logic [4:0]            commitRd_q,    commitRd_d;
  logic [DATA_WIDTH-1:0] commitData_q,  commitData_d;
  logic [31:0]           writeCount_q,  writeCount_d;

  logic                  commit;
  logic [DATA_WIDTH-1:0] rs1Data;
  logic [DATA_WIDTH-1:0] rs2Data;

  // A write to x0 is architecturally a no-op: it must not touch storage,
  // the trace or the counter.
  assign commit = i_ctrl_RegWrite && (i_Rd != 5'd0);

  // Next-state for the array. The index is matched with a loop rather than
  // a direct subscript so an index outside 1..REG_COUNT-1 simply misses.
  always_comb begin
    for (int r = 1; r < REG_COUNT; r++) begin
      regs_d[r] = regs_q[r];
      if (commit && (i_Rd == 5'(r))) begin
        regs_d[r] = i_WriteData;
      end
    end
  end

  // Commit trace captures only on a real commit; otherwise Rd/Data hold so the
  // last retired write stays visible while Valid drops.
  always_comb begin
    commitValid_d = commit;
    commitRd_d    = commitRd_q;
    commitData_d  = commitData_q;
    writeCount_d  = writeCount_q;
    if (commit) begin
      commitRd_d   = i_Rd;
      commitData_d = i_WriteData;
      writeCount_d = writeCount_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 1; r < REG_COUNT; r++) begin
        regs_q[r] <= '0;
      end
      commitValid_q <= 1'b0;
      commitRd_q    <= 5'd0;
      commitData_q  <= '0;
      writeCount_q  <= 32'd0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        regs_q[r] <= regs_d[r];
      end
      commitValid_q <= commitValid_d;
      commitRd_q    <= commitRd_d;
      commitData_q  <= commitData_d;
      writeCount_q  <= writeCount_d;
    end
  end

  // Read ports: x0 is hard zero, then the in-flight write wins over the stored
  // value so a consumer in ID sees the result in the same cycle.
  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (i_Rs1 == 5'(r)) rs1Data = regs_q[r];
      if (i_Rs2 == 5'(r)) rs2Data = regs_q[r];
    end
    if (commit && (i_Rd == i_Rs1)) rs1Data = i_WriteData;
    if (commit && (i_Rd == i_Rs2)) rs2Data = i_WriteData;
    if (i_Rs1 == 5'd0) rs1Data = '0;
    if (i_Rs2 == 5'd0) rs2Data = '0;
  end

  assign o_Rs1_Data     = rs1Data;
  assign o_Rs2_Data     = rs2Data;
  assign o_Commit_Valid = commitValid_q;
  assign o_Commit_Rd    = commitRd_q;
  assign o_Commit_Data  = commitData_q;
  assign o_Write_Count  = writeCount_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//
// Directed bench for reg_file. A behavioural model of the register array and
// commit trace computes expected values; each expectation is queued when
// stimulus is driven and popped and compared once the DUT output settles.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [31:0] writeData;
  logic        regWrite;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        commitValid;
  logic [4:0]  commitRd;
  logic [31:0] commitData;
  logic [31:0] writeCount;

  reg_file #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_WriteData     (writeData),
    .i_ctrl_RegWrite (regWrite),
    .i_Rd            (rd),
    .i_Rs1           (rs1),
    .i_Rs2           (rs2),
    .o_Rs1_Data      (rs1Data),
    .o_Rs2_Data      (rs2Data),
    .o_Commit_Valid  (commitValid),
    .o_Commit_Rd     (commitRd),
    .o_Commit_Data   (commitData),
    .o_Write_Count   (writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: which output to compare, the expected value, a tag.
  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } sbItem_t;

  sbItem_t     sbQueue[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  logic [31:0] modelRegs [0:31];
  logic        modelValid;
  logic [4:0]  modelRd;
  logic [31:0] modelData;
  logic [31:0] modelCount;

  function automatic logic [31:0] expRead(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (regWrite && (rd != 5'd0) && (rd == rs)) return writeData;
    return modelRegs[rs];
  endfunction

  task automatic pushExp(input int sel, input logic [31:0] exp, input string tag);
    sbItem_t it;
    it.sel = sel;
    it.exp = exp;
    it.tag = tag;
    sbQueue.push_back(it);
  endtask

  task automatic pushReads(input string tag);
    pushExp(0, expRead(rs1), {tag, ".rs1"});
    pushExp(1, expRead(rs2), {tag, ".rs2"});
  endtask

  task automatic pushCommit(input string tag);
    pushExp(2, {31'd0, modelValid}, {tag, ".cvalid"});
    pushExp(3, {27'd0, modelRd},    {tag, ".crd"});
    pushExp(4, modelData,           {tag, ".cdata"});
    pushExp(5, modelCount,          {tag, ".count"});
  endtask

  task automatic checkOutput;
    sbItem_t     it;
    logic [31:0] obs;
    while (sbQueue.size() > 0) begin
      it = sbQueue.pop_front();
      case (it.sel)
        0:       obs = rs1Data;
        1:       obs = rs2Data;
        2:       obs = {31'd0, commitValid};
        3:       obs = {27'd0, commitRd};
        4:       obs = commitData;
        default: obs = writeCount;
      endcase
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic modelReset;
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    modelValid = 1'b0;
    modelRd    = 5'd0;
    modelData  = 32'd0;
    modelCount = 32'd0;
  endtask

  // Drive one set of inputs (caller is just after a falling edge), check the
  // combinational reads, optionally clock once and check the state update.
  task automatic applyStimulus(input logic we, input logic [4:0] wrRd,
                               input logic [31:0] wd, input logic [4:0] r1,
                               input logic [4:0] r2, input bit doEdge,
                               input string tag);
    regWrite  = we;
    rd        = wrRd;
    writeData = wd;
    rs1       = r1;
    rs2       = r2;
    #1;
    pushReads({tag, ".pre"});
    checkOutput();
    if (doEdge) begin
      @(posedge clk);
      if (we && (wrRd != 5'd0)) begin
        modelRegs[wrRd] = wd;
        modelValid = 1'b1;
        modelRd    = wrRd;
        modelData  = wd;
        modelCount = modelCount + 32'd1;
      end else begin
        modelValid = 1'b0;
      end
      #1;
      pushReads({tag, ".post"});
      pushCommit(tag);
      checkOutput();
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    regWrite  = 1'b0;
    rd        = 5'd0;
    writeData = 32'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state on every index of both ports
    pushCommit("reset");
    checkOutput();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, "rstRead");
    end

    // Basic write and next-cycle read
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, "wrX5");
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, "rdX5");

    // Same-cycle bypass over an older value
    applyStimulus(1'b1, 5'd7, 32'h11, 5'd0, 5'd7, 1'b1, "wrX7");
    applyStimulus(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b1, "bypX7");
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b1, "rdX7");

    // Write x3 so the commit trace has a known last value
    applyStimulus(1'b1, 5'd3, 32'h1234, 5'd3, 5'd4, 1'b1, "wrX3");

    // x0 protection
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 1'b1, "x0");

    // Disabled write: no bypass, no storage, trace holds last Rd/Data
    applyStimulus(1'b0, 5'd3, 32'hABCD, 5'd3, 5'd3, 1'b1, "noWe");

    // Port 1 hits the write target while port 2 reads another register
    applyStimulus(1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd5, 1'b1, "mixed");

    // Back-to-back writes, then reset in the middle of a write
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 5'(i), 32'hA5000000 + 32'(i), 5'(i), 5'(i - 1), 1'b1, "b2b");
    end
    regWrite  = 1'b1;
    rd        = 5'd21;
    writeData = 32'hA5000015;
    rs1       = 5'd21;
    rs2       = 5'd20;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    pushReads("midRst");
    pushCommit("midRst");
    checkOutput();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, "inRst");
    end
    pushCommit("inRst");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Writes resume after release; check the lost x21 write stays zero
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd21, 5'd1, 1'b1, "postRst");
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h5A000000 + 32'(i * 3), 5'(i), 5'(32 - i), 1'b1, "resume");
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, "final");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
